// File: rtl/csa_pkg.sv
// Shared definitions for the stream_cypher packet sequencer.
package csa_pkg;

    localparam int unsigned CSA_BLK_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RUN
    } csa_state_e;

endpackage

// File: rtl/csa_ctrl_fifo.sv
// Small first-word-fall-through FIFO holding captured keystream words and their last tag.
module csa_ctrl_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 65,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          valid,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid    = (count != '0);
    assign do_pop   = pop & valid;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/csa_stream_ctrl.sv
// Sequences one stream_cypher over packets: init cycle on the first block, en cycles after,
// keystream words captured into a credit-protected output FIFO.
module csa_stream_ctrl
    import csa_pkg::*;
#(
    parameter int unsigned BLK_W     = CSA_BLK_W,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [BLK_W-1:0] key_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             sc_en,
    output logic             sc_init,
    output logic [BLK_W-1:0] sc_ck,
    output logic [BLK_W-1:0] sc_sb,
    input  logic [BLK_W-1:0] sc_cb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             pkt_done,
    output logic             err_seq
);

    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned UW = CW + 2;

    csa_state_e       state;
    logic [BLK_W-1:0] pend_key;
    logic             last_q;
    logic             cap_q;
    logic             cap_last;
    logic             en_q;
    logic             accept;
    logic             pop;
    logic [CW-1:0]    count;
    logic [UW-1:0]    used;

    // Two words can be in flight (en cycle, then cb cycle); both hold a FIFO slot until pushed.
    assign en_q   = sc_en & ~sc_init;
    assign pop    = out_valid & out_ready;
    assign used   = UW'(count) + UW'(en_q) + UW'(cap_q) - UW'(pop);
    assign accept = in_valid & in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            WAIT:    in_ready = 1'b1;
            RUN:     in_ready = (used < UW'(OUT_DEPTH));
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pend_key <= '0;
            sc_ck    <= '0;
            sc_sb    <= '0;
            sc_en    <= 1'b0;
            sc_init  <= 1'b0;
            last_q   <= 1'b0;
            cap_q    <= 1'b0;
            cap_last <= 1'b0;
            pkt_done <= 1'b0;
            err_seq  <= 1'b0;
        end else begin
            sc_en    <= 1'b0;
            sc_init  <= 1'b0;
            pkt_done <= 1'b0;
            err_seq  <= 1'b0;
            cap_q    <= en_q;
            cap_last <= last_q;
            if (key_valid) begin
                pend_key <= key_data;
            end
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state <= WAIT;
                    end
                end
                WAIT, RUN: begin
                    if (accept) begin
                        if (in_first) begin
                            sc_en    <= 1'b1;
                            sc_init  <= 1'b1;
                            sc_sb    <= in_data;
                            sc_ck    <= pend_key;
                            err_seq  <= (state == RUN);
                            pkt_done <= in_last;
                            state    <= in_last ? WAIT : RUN;
                        end else if (state == RUN) begin
                            sc_en    <= 1'b1;
                            sc_sb    <= in_data;
                            last_q   <= in_last;
                            pkt_done <= in_last;
                            if (in_last) begin
                                state <= WAIT;
                            end
                        end else begin
                            err_seq <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    csa_ctrl_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (BLK_W + 1),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_q),
        .push_data ({cap_last, sc_cb}),
        .pop       (out_ready),
        .pop_data  ({out_last, out_data}),
        .valid     (out_valid),
        .count     (count)
    );

endmodule

// File: tb/tb_csa_stream_ctrl.sv
// Randomized and directed bench for csa_stream_ctrl against a transaction-level packet model.
module tb_csa_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [63:0] key_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        sc_en;
    logic        sc_init;
    logic [63:0] sc_ck;
    logic [63:0] sc_sb;
    logic [63:0] sc_cb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        pkt_done;
    logic        err_seq;

    csa_stream_ctrl #(
        .BLK_W     (64),
        .OUT_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_data  (key_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .sc_en     (sc_en),
        .sc_init   (sc_init),
        .sc_ck     (sc_ck),
        .sc_sb     (sc_sb),
        .sc_cb     (sc_cb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pkt_done  (pkt_done),
        .err_seq   (err_seq)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mix(input logic [63:0] a, input logic [63:0] k);
        return {a[31:0], a[63:32]} ^ k ^ 64'h9E3779B97F4A7C15;
    endfunction

    // Stand-in for stream_cypher: cb registers a keyed function of sb on every en cycle.
    always @(posedge clk) begin
        if (sc_en) sc_cb <= mix(sc_sb, sc_ck);
    end

    typedef struct {
        logic [63:0] d;
        bit          l;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    bit          have_key, in_pkt, last_acc;
    logic [63:0] pend_m, ck_m, e_sb;
    bit          e_en, e_init, e_done, e_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        have_key = 0; in_pkt = 0; last_acc = 0;
        pend_m = '0; ck_m = '0; e_sb = '0;
        e_en = 0; e_init = 0; e_done = 0; e_err = 0;
        sbq.delete();
    endtask

    task automatic step(input bit v, input bit f, input bit l, input logic [63:0] d,
                        input bit ordy, input bit kv, input logic [63:0] kd);
        @(negedge clk);
        chk("sc_en", sc_en, e_en);
        chk("sc_init", sc_init, e_init);
        if (e_en) chk("sc_sb", sc_sb, e_sb);
        chk("sc_ck", sc_ck, ck_m);
        chk("pkt_done", pkt_done, e_done);
        chk("err_seq", err_seq, e_err);
        in_valid = v; in_first = f; in_last = l; in_data = d;
        out_ready = ordy; key_valid = kv; key_data = kd;
        #1;
        if (!have_key) chk("in_ready_nokey", in_ready, 0);
        else if (!in_pkt) chk("in_ready_wait", in_ready, 1);
        if (out_valid) begin
            if (sbq.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                chk("out_data", out_data, sbq[0].d);
                chk("out_last", out_last, sbq[0].l);
                if (ordy) begin
                    sbq.delete(0);
                    n_out++;
                end
            end
        end
        last_acc = v && in_ready;
        e_en = 0; e_init = 0; e_done = 0; e_err = 0;
        if (last_acc) begin
            if (f) begin
                e_en = 1; e_init = 1; e_sb = d; e_err = in_pkt;
                ck_m = pend_m; e_done = l; in_pkt = !l;
            end else if (in_pkt) begin
                e_en = 1; e_sb = d; e_done = l; in_pkt = !l;
                sbq.push_back('{mix(d, ck_m), l});
            end else begin
                e_err = 1;
            end
        end
        if (kv) begin
            pend_m = kd;
            have_key = 1;
        end
    endtask

    task automatic send(input bit f, input bit l, input logic [63:0] d, input bit ordy);
        int n = 0;
        do begin
            step(1, f, l, d, ordy, 0, '0);
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            step(0, 0, 0, '0, 1, 0, '0);
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
        step(0, 0, 0, '0, 1, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        in_valid = 0; in_first = 0; in_last = 0; key_valid = 0; out_ready = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sc_en", sc_en, 0);
        chk("rst_in_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    logic [63:0] blk [9];
    int          k, o0, n;

    initial begin
        model_reset();
        do_reset();
        chk("rst_sc_ck", sc_ck, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_err_seq", err_seq, 0);

        // No key loaded: first blocks are never accepted.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 64'h1111, 1, 0, '0);

        // Two-block packet with the reference vectors.
        step(0, 0, 0, '0, 1, 1, 64'h271F18110A02FBF4);
        o0 = n_out;
        send(1, 0, 64'hEDE6DED7D0C9C1BA, 1);
        send(0, 1, 64'hB3ACA49D968F8780, 1);
        drain();
        chk("pkt2_outputs", n_out - o0, 1);

        // Ten-block packet with downstream stalled, then released with a mid-packet key change.
        for (int i = 0; i < 9; i++) blk[i] = {$urandom, $urandom};
        o0 = n_out;
        send(1, 0, 64'hA5A5A5A5_5A5A5A5A, 0);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, k == 8, blk[k], 0, 0, '0);
            if (last_acc) k++;
        end
        chk("stall_en_count", k, 2);
        chk("stall_in_ready", in_ready, 0);
        n = 0;
        while (k < 9 && n < 60) begin
            step(1, 0, k == 8, blk[k], 1, k == 4, 64'h0123456789ABCDEF);
            if (last_acc) k++;
            n++;
        end
        chk("pkt10_issued", k, 9);
        drain();
        chk("pkt10_outputs", n_out - o0, 9);
        send(1, 1, 64'h55, 1);
        step(0, 0, 0, '0, 1, 0, '0);
        chk("ck_new", sc_ck, 64'h0123456789ABCDEF);

        // Sequencing errors: stray block in WAIT, restart inside RUN.
        step(1, 0, 0, 64'hDEAD, 1, 0, '0);
        send(1, 0, 64'h10, 1);
        send(0, 0, 64'h11, 1);
        send(1, 0, 64'h12, 1);
        send(0, 1, 64'h13, 1);
        drain();

        // Randomized traffic.
        step(0, 0, 0, '0, 1, 1, {$urandom, $urandom});
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                 {$urandom, $urandom});
        end
        step(0, 0, 0, '0, 1, 0, '0);
        drain();

        // Reset while running with a full FIFO.
        step(0, 0, 0, '0, 0, 1, 64'hFEED);
        send(1, 0, 64'h20, 0);
        send(0, 0, 64'h21, 0);
        send(0, 0, 64'h22, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, 0, '0);
        chk("full_before_rst", out_valid, 1);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 64'h30, 1, 0, '0);
        step(0, 0, 0, '0, 1, 1, 64'hBEEF);
        send(1, 1, 64'h31, 1);
        step(0, 0, 0, '0, 1, 0, '0);
        chk("ck_after_rst", sc_ck, 64'hBEEF);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
